gio_sched: RTL and testbench

Failsafe scheduler and bus arbiter placed between the CPU Wishbone port and the `gio` peripheral. It forwards CPU accesses to `gio` and runs a motor-command watchdog. On watchdog expiry it takes the bus and writes safe values into the PWM and PPM output registers. It then blocks further motor-command writes until software re-arms it through a local control register.

---
 rtl/gio_sched_pkg.sv | 50 +++++
 rtl/gio_sched_wdog.sv | 76 +++++++
 rtl/gio_sched.sv | 181 ++++++++++++++++++
 tb/tb_gio_sched.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/gio_sched_pkg.sv
// ============================================================================
// Module   : gio_sched_pkg
// Brief    : Shared definitions for the gio failsafe scheduler: bus FSM
//            states, guarded word indices, CTRL address and bit positions.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package gio_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FWD    = 2'd1,
        ST_FS_SEQ = 2'd2
    } bus_state_e;

    // gio word indices that carry motor commands (PWM pair, PPM pair)
    localparam logic [2:0] C_WIDX_PWM0 = 3'd1;
    localparam logic [2:0] C_WIDX_PWM1 = 3'd2;
    localparam logic [2:0] C_WIDX_PPM0 = 3'd6;
    localparam logic [2:0] C_WIDX_PPM1 = 3'd7;

    localparam logic [2:0] C_CTRL_WIDX = 3'd0;

    localparam int C_CTRL_ARMED_BIT = 0;
    localparam int C_CTRL_FS_BIT    = 1;
    localparam int C_CTRL_REARM_BIT = 0;
    localparam int C_CTRL_FCNT_LSB  = 8;
    localparam int C_CTRL_TMO_LSB   = 16;

    function automatic logic is_guarded(input logic [2:0] widx);
        return (widx == C_WIDX_PWM0) || (widx == C_WIDX_PWM1) ||
               (widx == C_WIDX_PPM0) || (widx == C_WIDX_PPM1);
    endfunction

    // Byte address of the failsafe write issued at a given sequencer step
    function automatic logic [7:0] fs_word_adr(input logic [1:0] step);
        logic [2:0] widx;
        case (step)
            2'd0:    widx = C_WIDX_PWM0;
            2'd1:    widx = C_WIDX_PWM1;
            2'd2:    widx = C_WIDX_PPM0;
            default: widx = C_WIDX_PPM1;
        endcase
        return {3'b000, widx, 2'b00};
    endfunction

endpackage

`default_nettype wire

// File: rtl/gio_sched_wdog.sv
// ============================================================================
// Module   : gio_sched_wdog
// Brief    : Motor-command watchdog: ms divider, ms counter, expiry compare,
//            armed flag, failsafe request and saturating fault counter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module gio_sched_wdog #(
    parameter int CLK_PER_MS = 50000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        kick_i,
    input  logic        rearm_i,
    input  logic        fs_ack_i,
    input  logic [15:0] timeout_i,
    output logic        armed_o,
    output logic        fs_pend_o,
    output logic [7:0]  fault_cnt_o
);

    localparam int DIV_W = (CLK_PER_MS > 1) ? $clog2(CLK_PER_MS) : 1;

    logic [DIV_W-1:0] div_q;
    logic [15:0]      ms_q;
    logic             armed_q;
    logic             fs_pend_q;
    logic [7:0]       fault_q;
    logic             tick;

    assign tick = (div_q == DIV_W'(CLK_PER_MS - 1));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            div_q     <= '0;
            ms_q      <= '0;
            armed_q   <= 1'b0;
            fs_pend_q <= 1'b0;
            fault_q   <= '0;
        end else begin
            div_q <= tick ? '0 : div_q + DIV_W'(1);

            if (fs_ack_i) begin
                fs_pend_q <= 1'b0;
            end

            if (rearm_i) begin
                armed_q <= 1'b1;
                ms_q    <= '0;
            end else if (!armed_q || kick_i) begin
                ms_q <= '0;
            end else if (tick) begin
                // Expiry is judged on a tick, so after a kick at least
                // timeout full milliseconds elapse whatever the divider phase.
                if ((timeout_i != 16'd0) && (ms_q == timeout_i)) begin
                    fs_pend_q <= 1'b1;
                    armed_q   <= 1'b0;
                    ms_q      <= '0;
                    if (fault_q != 8'hFF) begin
                        fault_q <= fault_q + 8'd1;
                    end
                end else begin
                    ms_q <= ms_q + 16'd1;
                end
            end
        end
    end

    assign armed_o     = armed_q;
    assign fs_pend_o   = fs_pend_q;
    assign fault_cnt_o = fault_q;

endmodule

`default_nettype wire

// File: rtl/gio_sched.sv
// ============================================================================
// Module   : gio_sched
// Brief    : Failsafe scheduler and Wishbone arbiter between the CPU and gio.
//            Forwards CPU traffic, runs the watchdog, and on expiry writes
//            safe PWM/PPM values then blocks motor writes until re-armed.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module gio_sched
    import gio_sched_pkg::*;
#(
    parameter int          CLK_PER_MS  = 50000,
    parameter logic [15:0] TIMEOUT_RST = 16'd250,
    parameter logic [31:0] PPM_SAFE    = 32'h80808080
) (
    input  logic        wb_clk,
    input  logic        wb_rst,
    input  logic        c_cyc,
    input  logic        c_stb,
    input  logic        c_we,
    input  logic [3:0]  c_sel,
    input  logic [7:0]  c_adr,
    input  logic [31:0] c_dat,
    output logic [31:0] c_rdt,
    output logic        c_ack,
    output logic        g_cyc,
    output logic        g_stb,
    output logic        g_we,
    output logic [3:0]  g_sel,
    output logic [7:0]  g_adr,
    output logic [31:0] g_dat,
    input  logic [31:0] g_rdt,
    input  logic        g_ack,
    output logic        fs_active
);

    bus_state_e  state_q;
    logic [1:0]  fs_step_q;
    logic        fs_gap_q;
    logic [15:0] timeout_q;

    logic        armed;
    logic        fs_pend;
    logic [7:0]  fault_cnt;

    logic        req;
    logic        is_local;
    logic        is_ctrl;
    logic        guarded;
    logic        accept;
    logic        kick;
    logic        rearm;
    logic        tmo_load;
    logic        fs_start;
    logic [31:0] ctrl_rdata;

    // A stb still high during the ack cycle belongs to the finished access.
    assign req      = c_cyc && c_stb && !c_ack;
    assign is_local = |c_adr[7:5];
    assign is_ctrl  = is_local && (c_adr[4:2] == C_CTRL_WIDX);
    assign guarded  = !is_local && is_guarded(c_adr[4:2]);

    assign fs_start = (state_q == ST_IDLE) && fs_pend;
    assign accept   = (state_q == ST_IDLE) && !fs_pend && req;
    assign kick     = accept && c_we && guarded && armed;
    assign rearm    = accept && c_we && is_ctrl && c_sel[0] && c_dat[C_CTRL_REARM_BIT];
    assign tmo_load = accept && c_we && is_ctrl && (&c_sel[3:2]);

    assign fs_active = !armed;

    always_comb begin
        ctrl_rdata                                = '0;
        ctrl_rdata[C_CTRL_ARMED_BIT]              = armed;
        ctrl_rdata[C_CTRL_FS_BIT]                 = fs_active;
        ctrl_rdata[C_CTRL_FCNT_LSB +: 8]          = fault_cnt;
        ctrl_rdata[C_CTRL_TMO_LSB +: 16]          = timeout_q;
    end

    gio_sched_wdog #(
        .CLK_PER_MS (CLK_PER_MS)
    ) u_wdog (
        .clk_i       (wb_clk),
        .rst_i       (wb_rst),
        .kick_i      (kick),
        .rearm_i     (rearm),
        .fs_ack_i    (fs_start),
        .timeout_i   (timeout_q),
        .armed_o     (armed),
        .fs_pend_o   (fs_pend),
        .fault_cnt_o (fault_cnt)
    );

    always_ff @(posedge wb_clk or posedge wb_rst) begin
        if (wb_rst) begin
            state_q   <= ST_IDLE;
            fs_step_q <= 2'd0;
            fs_gap_q  <= 1'b0;
            timeout_q <= TIMEOUT_RST;
            c_rdt     <= '0;
            c_ack     <= 1'b0;
            g_cyc     <= 1'b0;
            g_stb     <= 1'b0;
            g_we      <= 1'b0;
            g_sel     <= '0;
            g_adr     <= '0;
            g_dat     <= '0;
        end else begin
            c_ack <= 1'b0;
            if (tmo_load) begin
                timeout_q <= c_dat[C_CTRL_TMO_LSB +: 16];
            end

            case (state_q)
                ST_IDLE: begin
                    if (fs_pend) begin
                        state_q   <= ST_FS_SEQ;
                        fs_step_q <= 2'd0;
                        fs_gap_q  <= 1'b0;
                        g_cyc     <= 1'b1;
                        g_stb     <= 1'b1;
                        g_we      <= 1'b1;
                        g_sel     <= 4'hF;
                        g_adr     <= fs_word_adr(2'd0);
                        g_dat     <= '0;
                    end else if (req) begin
                        if (is_local) begin
                            c_ack <= 1'b1;
                            c_rdt <= (is_ctrl && !c_we) ? ctrl_rdata : '0;
                        end else if (c_we && guarded && !armed) begin
                            c_ack <= 1'b1;
                            c_rdt <= '0;
                        end else begin
                            state_q <= ST_FWD;
                            g_cyc   <= 1'b1;
                            g_stb   <= 1'b1;
                            g_we    <= c_we;
                            g_sel   <= c_sel;
                            g_adr   <= c_adr;
                            g_dat   <= c_dat;
                        end
                    end
                end

                ST_FWD: begin
                    if (g_ack) begin
                        state_q <= ST_IDLE;
                        g_cyc   <= 1'b0;
                        g_stb   <= 1'b0;
                        c_rdt   <= g_rdt;
                        c_ack   <= 1'b1;
                    end
                end

                ST_FS_SEQ: begin
                    if (fs_gap_q) begin
                        fs_gap_q <= 1'b0;
                        g_cyc    <= 1'b1;
                        g_stb    <= 1'b1;
                        g_adr    <= fs_word_adr(fs_step_q);
                        g_dat    <= fs_step_q[1] ? PPM_SAFE : 32'd0;
                    end else if (g_ack) begin
                        g_cyc <= 1'b0;
                        g_stb <= 1'b0;
                        if (fs_step_q == 2'd3) begin
                            state_q <= ST_IDLE;
                        end else begin
                            fs_step_q <= fs_step_q + 2'd1;
                            fs_gap_q  <= 1'b1;
                        end
                    end
                end

                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_gio_sched.sv
// ============================================================================
// Module   : tb_gio_sched
// Brief    : Directed self-checking bench for gio_sched with a simple gio
//            slave model that logs the writes it accepts.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_gio_sched;

    localparam int          CLK_PER_MS = 20;
    localparam logic [31:0] PPM        = 32'h80808080;

    logic        wb_clk = 1'b0;
    logic        wb_rst = 1'b1;
    logic        c_cyc = 1'b0, c_stb = 1'b0, c_we = 1'b0;
    logic [3:0]  c_sel = '0;
    logic [7:0]  c_adr = '0;
    logic [31:0] c_dat = '0;
    logic [31:0] c_rdt;
    logic        c_ack;
    logic        g_cyc, g_stb, g_we;
    logic [3:0]  g_sel;
    logic [7:0]  g_adr;
    logic [31:0] g_dat;
    logic [31:0] g_rdt;
    logic        g_ack;
    logic        fs_active;

    always #5 wb_clk = ~wb_clk;

    gio_sched #(
        .CLK_PER_MS  (CLK_PER_MS),
        .TIMEOUT_RST (16'd250),
        .PPM_SAFE    (PPM)
    ) dut (
        .wb_clk    (wb_clk),
        .wb_rst    (wb_rst),
        .c_cyc     (c_cyc),
        .c_stb     (c_stb),
        .c_we      (c_we),
        .c_sel     (c_sel),
        .c_adr     (c_adr),
        .c_dat     (c_dat),
        .c_rdt     (c_rdt),
        .c_ack     (c_ack),
        .g_cyc     (g_cyc),
        .g_stb     (g_stb),
        .g_we      (g_we),
        .g_sel     (g_sel),
        .g_adr     (g_adr),
        .g_dat     (g_dat),
        .g_rdt     (g_rdt),
        .g_ack     (g_ack),
        .fs_active (fs_active)
    );

    // gio slave model: registered ack after ack_delay extra cycles
    logic [31:0] mem [8];
    logic [7:0]  log_adr [$];
    logic [31:0] log_dat [$];
    int          ack_delay = 0;
    int          ack_cnt;
    logic        stb_seen = 1'b0;

    assign g_rdt = mem[g_adr[4:2]];

    always @(posedge wb_clk or posedge wb_rst) begin
        if (wb_rst) begin
            g_ack   <= 1'b0;
            ack_cnt <= 0;
        end else begin
            if (g_stb) stb_seen = 1'b1;
            if (g_cyc && g_stb && g_ack && g_we) begin
                log_adr.push_back(g_adr);
                log_dat.push_back(g_dat);
                for (int b = 0; b < 4; b++)
                    if (g_sel[b]) mem[g_adr[4:2]][8*b +: 8] = g_dat[8*b +: 8];
            end
            if (g_cyc && g_stb && !g_ack) begin
                if (ack_cnt >= ack_delay) begin
                    g_ack   <= 1'b1;
                    ack_cnt <= 0;
                end else begin
                    ack_cnt <= ack_cnt + 1;
                end
            end else begin
                g_ack <= 1'b0;
            end
        end
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic wb_xfer(input logic we, input logic [7:0] adr, input logic [3:0] sel,
                           input logic [31:0] dat, output logic [31:0] rdt, output int lat);
        @(posedge wb_clk); #1;
        c_cyc = 1'b1; c_stb = 1'b1; c_we = we; c_adr = adr; c_sel = sel; c_dat = dat;
        lat = 0;
        while (lat < 1000) begin
            @(posedge wb_clk); lat++; #1;
            if (c_ack) break;
        end
        if (!c_ack) chk("xfer_timeout", {31'd0, c_ack}, 32'd1);
        rdt = c_rdt;
        c_cyc = 1'b0; c_stb = 1'b0; c_we = 1'b0;
    endtask

    task automatic wait_log(input int n, input int bound);
        int cyc = 0;
        while (log_adr.size() < n && cyc < bound) begin
            @(posedge wb_clk); #1; cyc++;
        end
        chk("log_count", log_adr.size(), n);
    endtask

    task automatic check_seq(input string tag);
        logic [7:0]  ea [4] = '{8'h04, 8'h08, 8'h18, 8'h1C};
        logic [31:0] ed [4] = '{32'd0, 32'd0, PPM, PPM};
        for (int i = 0; i < 4; i++) begin
            if (i < log_adr.size()) begin
                chk($sformatf("%s_adr%0d", tag, i), {24'd0, log_adr[i]}, {24'd0, ea[i]});
                chk($sformatf("%s_dat%0d", tag, i), log_dat[i], ed[i]);
            end else begin
                chk($sformatf("%s_missing%0d", tag, i), log_adr.size(), i + 1);
            end
        end
    endtask

    task automatic clr_log();
        log_adr.delete();
        log_dat.delete();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        logic [31:0] rd;
        int          lat;
        int          cyc;

        for (int i = 0; i < 8; i++) mem[i] = '0;
        repeat (3) @(posedge wb_clk);
        #1;
        wb_rst = 1'b0;
        chk("rst_g_cyc", {31'd0, g_cyc}, 32'd0);
        chk("rst_g_stb", {31'd0, g_stb}, 32'd0);
        chk("rst_c_ack", {31'd0, c_ack}, 32'd0);
        chk("rst_c_rdt", c_rdt, 32'd0);
        chk("rst_fs_active", {31'd0, fs_active}, 32'd1);

        wb_xfer(1'b0, 8'h20, 4'hF, 32'd0, rd, lat);
        chk("ctrl_rst", rd, 32'h00FA0002);
        chk("local_lat", lat, 1);

        wb_xfer(1'b1, 8'h20, 4'hF, 32'h00FA0001, rd, lat);
        wb_xfer(1'b0, 8'h20, 4'hF, 32'd0, rd, lat);
        chk("ctrl_armed", rd, 32'h00FA0001);
        chk("armed_fs_active", {31'd0, fs_active}, 32'd0);

        wb_xfer(1'b1, 8'h04, 4'hF, 32'h11223344, rd, lat);
        chk("fwd_lat", lat, 3);
        chk("fwd_data", mem[1], 32'h11223344);

        // 2 ms timeout, no kicks
        clr_log();
        wb_xfer(1'b1, 8'h20, 4'hF, 32'h00020001, rd, lat);
        wait_log(4, 400);
        check_seq("fs1");
        wb_xfer(1'b0, 8'h20, 4'hF, 32'd0, rd, lat);
        chk("ctrl_after_fs", rd, 32'h00020102);
        chk("fs_active_hold", {31'd0, fs_active}, 32'd1);

        // HOLD: guarded write dropped, unguarded forwarded
        stb_seen = 1'b0;
        wb_xfer(1'b1, 8'h08, 4'hF, 32'h00000055, rd, lat);
        chk("drop_lat", lat, 1);
        chk("drop_no_stb", {31'd0, stb_seen}, 32'd0);
        chk("drop_mem", mem[2], 32'd0);
        wb_xfer(1'b1, 8'h00, 4'hF, 32'h0000A5A5, rd, lat);
        chk("hold_fwd_lat", lat, 3);
        chk("hold_fwd_mem", mem[0], 32'h0000A5A5);

        // Re-arm, then kick roughly every 1.5 ms for about 20 ms
        wb_xfer(1'b1, 8'h20, 4'h1, 32'h00000001, rd, lat);
        clr_log();
        for (int k = 0; k < 14; k++) begin
            wb_xfer(1'b1, 8'h18, 4'hF, k, rd, lat);
            repeat (25) @(posedge wb_clk);
        end
        chk("kick_log_count", log_adr.size(), 14);
        wb_xfer(1'b0, 8'h20, 4'hF, 32'd0, rd, lat);
        chk("ctrl_after_kicks", rd, 32'h00020101);

        // Expiry while a slow read sits in FWD
        mem[3] = 32'hCAFEF00D;
        ack_delay = 100;
        clr_log();
        wb_xfer(1'b0, 8'h0C, 4'hF, 32'd0, rd, lat);
        ack_delay = 0;
        chk("fwd_read_data", rd, 32'hCAFEF00D);
        chk("fwd_no_fs_yet", log_adr.size(), 0);
        chk("fwd_expired", {31'd0, fs_active}, 32'd1);
        wb_xfer(1'b0, 8'h20, 4'hF, 32'd0, rd, lat);
        chk("stall_log_count", log_adr.size(), 4);
        check_seq("fs2");
        chk("stall_ctrl", rd, 32'h00020202);
        chk("stall_lat", {31'd0, lat > 4}, 32'd1);

        // Async reset during the 2nd sequencer write
        wb_xfer(1'b1, 8'h20, 4'h1, 32'h00000001, rd, lat);
        clr_log();
        wait_log(1, 400);
        cyc = 0;
        while (!(g_stb && g_adr == 8'h08) && cyc < 20) begin
            @(posedge wb_clk); #1; cyc++;
        end
        chk("seq2_seen", {31'd0, g_stb}, 32'd1);
        wb_rst = 1'b1;
        #1;
        chk("mrst_g_cyc", {31'd0, g_cyc}, 32'd0);
        chk("mrst_g_stb", {31'd0, g_stb}, 32'd0);
        chk("mrst_g_we", {31'd0, g_we}, 32'd0);
        chk("mrst_g_adr", {24'd0, g_adr}, 32'd0);
        chk("mrst_g_dat", g_dat, 32'd0);
        chk("mrst_g_sel", {28'd0, g_sel}, 32'd0);
        chk("mrst_c_ack", {31'd0, c_ack}, 32'd0);
        chk("mrst_c_rdt", c_rdt, 32'd0);
        chk("mrst_fs_active", {31'd0, fs_active}, 32'd1);
        @(posedge wb_clk); #1;
        wb_rst = 1'b0;
        stb_seen = 1'b0;
        repeat (50) @(posedge wb_clk);
        #1;
        chk("mrst_abandoned", {31'd0, stb_seen}, 32'd0);
        wb_xfer(1'b0, 8'h20, 4'hF, 32'd0, rd, lat);
        chk("mrst_ctrl", rd, 32'h00FA0002);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
